// File: rtl/game_pkg.sv
// Shared game-flow types: session state encoding and background screen codes.
// Pure declarations; no latency or flow control of its own.
package game_pkg;

  typedef enum logic [1:0] {
    WELCOME   = 2'd0,
    PLAY      = 2'd1,
    HIT_PAUSE = 2'd2,
    GAMEOVER  = 2'd3
  } state_e;

  localparam logic [1:0] SCREEN_WELCOME  = 2'd0;
  localparam logic [1:0] SCREEN_PLAY     = 2'd1;
  localparam logic [1:0] SCREEN_GAMEOVER = 2'd2;

  // The hit pause keeps the play background so the frozen field stays visible.
  function automatic logic [1:0] screen_of(input state_e s);
    logic [1:0] scr;
    scr = SCREEN_WELCOME;
    case (s)
      PLAY, HIT_PAUSE: scr = SCREEN_PLAY;
      GAMEOVER:        scr = SCREEN_GAMEOVER;
      default:         scr = SCREEN_WELCOME;
    endcase
    return scr;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle pulse on a 0->1 transition of a level input; combinational off a 1-cycle history.
// No flow control. History resets to 1 so a level held through reset never fires.
module rise_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic outPulse
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!resetN) prev_q <= 1'b1;
    else         prev_q <= in;
  end

  assign outPulse = in & ~prev_q;

endmodule

// File: rtl/game_screen_fsm.sv
// Game session controller: state, lives, level, restart pulses and a frame-aligned screen selector.
// Outputs update 1 cycle after the triggering input; selector only moves on startOfFrame. No backpressure.
module game_screen_fsm
  import game_pkg::*;
#(
  parameter int LIVES            = 3,
  parameter int MAX_LEVEL        = 5,
  parameter int HIT_PAUSE_FRAMES = 60,
  parameter int GAMEOVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       playerHit,
  input  logic       levelCleared,
  output logic [1:0] selector,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       gameActive,
  output logic       won,
  output logic       newGame,
  output logic       newLevel
);

  localparam int CNT_W = $clog2(max_int(HIT_PAUSE_FRAMES, GAMEOVER_FRAMES) + 1);
  localparam logic [CNT_W-1:0] HIT_LOAD   = CNT_W'(HIT_PAUSE_FRAMES);
  localparam logic [CNT_W-1:0] GO_LOAD    = CNT_W'(GAMEOVER_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [2:0]       LEVEL_LAST = 3'(MAX_LEVEL);

  state_e           state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [2:0]       level_q, level_d;
  logic             won_q, won_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_game_q, new_game_d;
  logic             new_level_q, new_level_d;
  logic [1:0]       selector_q;
  logic             start_edge;

  rise_edge_detect u_start_edge (
    .clk      (clk),
    .resetN   (resetN),
    .in       (startKey),
    .outPulse (start_edge)
  );

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    won_d       = won_q;
    cnt_d       = cnt_q;
    new_game_d  = 1'b0;
    new_level_d = 1'b0;
    case (state_q)
      WELCOME: begin
        if (start_edge) begin
          state_d     = PLAY;
          lives_d     = LIVES_INIT;
          level_d     = 3'd0;
          won_d       = 1'b0;
          new_game_d  = 1'b1;
          new_level_d = 1'b1;
        end
      end
      PLAY: begin
        // A hit outranks a simultaneous clear; the clear is dropped.
        if (playerHit) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            cnt_d   = HIT_LOAD;
            state_d = HIT_PAUSE;
          end else begin
            lives_d = 2'd0;
            cnt_d   = GO_LOAD;
            state_d = GAMEOVER;
          end
        end else if (levelCleared) begin
          if (level_q < LEVEL_LAST) begin
            level_d     = level_q + 3'd1;
            new_level_d = 1'b1;
          end else begin
            won_d   = 1'b1;
            cnt_d   = GO_LOAD;
            state_d = GAMEOVER;
          end
        end
      end
      HIT_PAUSE: begin
        // Leave on the frame that would take the counter to zero.
        if (startOfFrame) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d       = '0;
            state_d     = PLAY;
            new_level_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      GAMEOVER: begin
        if (start_edge) begin
          cnt_d   = '0;
          state_d = WELCOME;
        end else if (startOfFrame) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            state_d = WELCOME;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: state_d = WELCOME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= WELCOME;
      lives_q     <= 2'd0;
      level_q     <= 3'd0;
      won_q       <= 1'b0;
      cnt_q       <= '0;
      new_game_q  <= 1'b0;
      new_level_q <= 1'b0;
      selector_q  <= SCREEN_WELCOME;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      won_q       <= won_d;
      cnt_q       <= cnt_d;
      new_game_q  <= new_game_d;
      new_level_q <= new_level_d;
      if (startOfFrame) selector_q <= screen_of(state_d);
    end
  end

  assign selector   = selector_q;
  assign lives      = lives_q;
  assign level      = level_q;
  assign won        = won_q;
  assign gameActive = (state_q == PLAY);
  assign newGame    = new_game_q;
  assign newLevel   = new_level_q;

endmodule

// File: tb/tb_game_screen_fsm.sv
// Directed bench for game_screen_fsm: table of single-cycle vectors, then hand sequences for frame timing.
module tb_game_screen_fsm;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, startKey, playerHit, levelCleared;
  logic [1:0] selector, lives;
  logic [2:0] level;
  logic       gameActive, won, newGame, newLevel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_screen_fsm dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startKey     (startKey),
    .playerHit    (playerHit),
    .levelCleared (levelCleared),
    .selector     (selector),
    .lives        (lives),
    .level        (level),
    .gameActive   (gameActive),
    .won          (won),
    .newGame      (newGame),
    .newLevel     (newLevel)
  );

  typedef struct {
    logic       r, s, k, h, c;
    logic [1:0] sel, lv;
    logic [2:0] lvl;
    logic       act, wn, ng, nl;
    string      nm;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chkall(input string nm, input int sel, input int lv, input int lvl,
                        input int act, input int wn, input int ng, input int nl);
    chk({nm, ".selector"},   int'(selector),   sel);
    chk({nm, ".lives"},      int'(lives),      lv);
    chk({nm, ".level"},      int'(level),      lvl);
    chk({nm, ".gameActive"}, int'(gameActive), act);
    chk({nm, ".won"},        int'(won),        wn);
    chk({nm, ".newGame"},    int'(newGame),    ng);
    chk({nm, ".newLevel"},   int'(newLevel),   nl);
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumes them.
  task automatic cyc(input logic r, input logic s, input logic k, input logic h, input logic c);
    resetN = r; startOfFrame = s; startKey = k; playerHit = h; levelCleared = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             r  s  k  h  c  sel lv lvl act wn ng nl
    tbl[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,3'd0, 1'b0,1'b0,1'b0,1'b0, "reset_key_held"};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,3'd0, 1'b0,1'b0,1'b0,1'b0, "reset_again"};
    tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,3'd0, 1'b0,1'b0,1'b0,1'b0, "held_key_no_start"};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,3'd0, 1'b0,1'b0,1'b0,1'b0, "key_release"};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd3,3'd0, 1'b1,1'b0,1'b1,1'b1, "key_press_start"};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd3,3'd0, 1'b1,1'b0,1'b0,1'b0, "pulses_end"};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'd1,2'd3,3'd0, 1'b1,1'b0,1'b0,1'b0, "frame_sel_play"};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 2'd1,2'd3,3'd1, 1'b1,1'b0,1'b0,1'b1, "clear_lvl0"};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd3,3'd1, 1'b1,1'b0,1'b0,1'b0, "idle_lvl1"};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 2'd1,2'd2,3'd1, 1'b0,1'b0,1'b0,1'b0, "hit_and_clear"};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd2,3'd1, 1'b0,1'b0,1'b0,1'b0, "pause_idle"};

    resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b1; playerHit = 1'b0; levelCleared = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].k, tbl[i].h, tbl[i].c);
      chkall(tbl[i].nm, tbl[i].sel, tbl[i].lv, tbl[i].lvl, tbl[i].act, tbl[i].wn, tbl[i].ng, tbl[i].nl);
    end

    // First pause: 60 frames; hits, clears and key presses are ignored meanwhile.
    for (int i = 1; i < 60; i++) begin
      cyc(1'b1, 1'b1, i == 20, i == 10, i == 30);
      chk($sformatf("pause1_f%0d.gameActive", i), int'(gameActive), 0);
      chk($sformatf("pause1_f%0d.lives", i), int'(lives), 2);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chkall("pause1_f59_idle", 1, 2, 1, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chkall("pause1_end", 1, 2, 1, 1, 0, 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chkall("pause1_after", 1, 2, 1, 1, 0, 0, 0);

    // Second hit with a coinciding frame pulse and clear: the entry frame is not counted.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chkall("hit2_entry", 1, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i < 60; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("pause2_f%0d.gameActive", i), int'(gameActive), 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chkall("pause2_end", 1, 1, 1, 1, 0, 0, 1);

    // Fatal hit mid-frame: selector holds until the next frame pulse.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chkall("hit3_gameover", 1, 0, 1, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gameover_midframe.selector", int'(selector), 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gameover_frame1.selector", int'(selector), 2);
    for (int i = 2; i < 180; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("gameover_f%0d.selector", i), int'(selector), 2);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chkall("gameover_timeout", 0, 0, 1, 0, 0, 0, 0);

    // New game, clear every level, win on the last one.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chkall("game2_start", 0, 3, 0, 1, 0, 1, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chkall("game2_frame", 1, 3, 0, 1, 0, 0, 0);
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chkall($sformatf("clear_to_%0d", j), 1, 3, j, 1, 0, 0, 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("clear_to_%0d_idle.newLevel", j), int'(newLevel), 0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chkall("clear_last_win", 1, 3, 5, 0, 1, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("win_frame.selector", int'(selector), 2);

    // Start edge cuts the game-over hold short.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chkall("gameover_key", 2, 3, 5, 0, 1, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chkall("gameover_key_frame", 0, 3, 5, 0, 1, 0, 0);

    // Third game: won clears, then reset lands mid-pause.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chkall("game3_start", 0, 3, 0, 1, 0, 1, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chkall("game3_hit", 1, 2, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chkall("reset_in_pause", 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chkall("after_reset", 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_screen_fsm.md
# game_screen_fsm

Top-level game flow controller for the Bubble Trouble display path. It tracks the session state (welcome, playing, hit pause, game over), lives and level, and drives the 2-bit screen selector consumed by the background multiplexer: 0 = welcome, 1 = play, 2 = game over. Selector changes are applied only at frame start, so a background switch never tears mid-frame. It also issues one-cycle restart pulses to the ball, player and rope logic.

## Interface
Parameters:
- LIVES, 3: lives granted at new game; 1..3.
- MAX_LEVEL, 5: index of the last level; clearing it ends the game as a win; 0..7.
- HIT_PAUSE_FRAMES, 60: frames the play field is frozen after a non-fatal hit; ≥1.
- GAMEOVER_FRAMES, 180: frames the game-over screen is held before returning to welcome; ≥1.

Ports:
- clk  in  1  system clock (pixel clock domain).
- resetN  in  1  synchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- startKey  in  1  level from the keypad decoder; only its rising edge acts.
- playerHit  in  1  one-cycle pulse when a ball hits the player.
- levelCleared  in  1  one-cycle pulse when the last ball of the level is popped.
- selector  out  2  registered screen select for the background multiplexer.
- lives  out  2  remaining lives.
- level  out  3  current level index.
- gameActive  out  1  1 only in PLAY; gates movement logic.
- won  out  1  1 when the last game ended by clearing MAX_LEVEL.
- newGame  out  1  one-cycle pulse on entry to PLAY from WELCOME.
- newLevel  out  1  one-cycle pulse when a level (re)starts, including after a hit pause.

## Operation
- Reset (resetN=0 at a clk edge):
  - state=WELCOME, selector=0, lives=0, level=0.
  - gameActive=0, won=0, newGame=0, newLevel=0, frame counter=0.
  - Reset has priority over every input. Mid-game reset returns to WELCOME on the next edge; no pulses are emitted.
- startKey rising edge: startKey=1 this cycle and 0 the previous cycle. The registered previous value resets to 1, so a key held through reset does not start a game.
- WELCOME:
  - On a start edge: go to PLAY. Set lives=LIVES, level=0, won=0. Pulse newGame and newLevel.
- PLAY:
  - playerHit with lives>1: lives−1, load counter=HIT_PAUSE_FRAMES, go to HIT_PAUSE.
  - playerHit with lives==1: lives=0, load counter=GAMEOVER_FRAMES, go to GAMEOVER.
  - levelCleared with level<MAX_LEVEL: level+1, pulse newLevel, stay in PLAY.
  - levelCleared with level==MAX_LEVEL: won=1, load counter=GAMEOVER_FRAMES, go to GAMEOVER.
  - playerHit and levelCleared in the same cycle: the hit wins and levelCleared is dropped.
- HIT_PAUSE:
  - Decrement the counter on each startOfFrame.
  - When the counter reaches 0, go to PLAY and pulse newLevel; level is unchanged.
  - playerHit, levelCleared and startKey are ignored.
- GAMEOVER:
  - Decrement the counter on each startOfFrame.
  - Go to WELCOME when the counter reaches 0 or on a start edge, whichever comes first.
  - lives, level and won hold their values until the next new game.
- Screen mapping: WELCOME→0, PLAY→1, HIT_PAUSE→1, GAMEOVER→2. The value 3 is never driven.
- Counter width is $clog2(max(HIT_PAUSE_FRAMES, GAMEOVER_FRAMES)+1). It never wraps: decrementing at 0 does not occur, because the transition fires at 0.

## Timing
- State, lives, level, won, gameActive and the pulses update on the clk edge that samples the triggering input: latency 1 cycle.
- selector loads the mapping of the next state only on edges where startOfFrame=1, and otherwise holds.
  - Worst-case lag is one frame.
  - If the state changes on the same edge as startOfFrame, selector takes the new state's value on that edge.
- Counter semantics: exactly N startOfFrame pulses after entry to HIT_PAUSE or GAMEOVER, the state leaves on the edge of the Nth pulse.
- The entry cycle never counts: a startOfFrame coinciding with the transition into the state is not a decrement.
- newGame and newLevel are high for exactly one cycle and never on consecutive cycles.

## Structure
- Shared package game_pkg holds:
  - the state enum (WELCOME, PLAY, HIT_PAUSE, GAMEOVER);
  - screen constants SCREEN_WELCOME=2'd0, SCREEN_PLAY=2'd1, SCREEN_GAMEOVER=2'd2.
- The background multiplexer and this block both use these constants.
- One sub-module: rise_edge_detect (clk, resetN, in, outPulse), used for startKey.
- The rest is a single always_ff state/counter process plus an always_comb next-state process.

## Test plan
- Reset with startKey held at 1, then release and press: no start until the press; on the press, newGame and newLevel pulse, lives=3, level=0; selector=1 after the next startOfFrame.
- Three playerHit pulses, each after the pause expires: lives 2→1→0. HIT_PAUSE lasts exactly 60 startOfFrame pulses; the third hit reaches GAMEOVER with selector=2 at the next frame; 180 frames later selector=0.
- Clear levels 0..5: level increments to 5. The sixth levelCleared gives won=1 and state GAMEOVER; lives are unchanged.
- playerHit and levelCleared in the same cycle with lives=2: lives=1, level unchanged, state HIT_PAUSE.
- State change mid-frame: selector holds its old value until the next startOfFrame, then changes exactly on that edge.
- resetN=0 during HIT_PAUSE: next cycle state=WELCOME, selector=0, lives=0, and no newLevel pulse.
